// File: rtl/riscv_ctrl_pkg.sv
// Shared opcode constants, select encodings and the control bundle type
// for the pipelined control/hazard block of the RV64 sorting core.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_BUBBLE = 7'b0000000;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LD     = 7'b0000011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_SD     = 7'b0100011;
    localparam logic [6:0] OP_BR     = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_JAL = 2'b11;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef struct packed {
        logic       branch;
        logic       mem_read;
        logic       memto_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_decoder.sv
// Purely combinational opcode -> control bundle table for the ID stage.
// Unknown opcodes produce an all-zero bundle and raise illegal.
module ctrl_decoder
    import riscv_ctrl_pkg::*;
#(
    parameter int SUPPORT_JAL = 0
) (
    input  logic [6:0]   opcode,
    output ctrl_bundle_t ctrl,
    output logic         illegal
);

    // Opcode table; every field defaults to 0 so nothing is left as x.
    always_comb begin
        ctrl    = CTRL_NOP;
        illegal = 1'b0;
        case (opcode)
            OP_BUBBLE: ;
            OP_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_R;
            end
            OP_LD: begin
                ctrl.mem_read  = 1'b1;
                ctrl.memto_reg = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_ADD;
            end
            OP_ADDI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_ADD;
            end
            OP_SD: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALUOP_ADD;
            end
            OP_BR: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALUOP_BR;
            end
            OP_JAL: begin
                if (SUPPORT_JAL != 0) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = ALUOP_JAL;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// Control and hazard block: decodes ID, carries control through
// ID/EX (_p0), EX/MEM (_p1) and MEM/WB (_p2), and generates load-use
// stall, branch flush and EX operand-forwarding selects.
module pipelined_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int SUPPORT_JAL = 0,
    parameter int FWD_EN      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            id_opcode,
    input  logic [2:0]            id_funct3,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  branch_taken,
    output logic                  ex_ALUSrc,
    output logic [1:0]            ex_ALUOp,
    output logic                  ex_Branch,
    output logic [2:0]            ex_funct3,
    output logic                  mem_MemRead,
    output logic                  mem_MemWrite,
    output logic                  wb_RegWrite,
    output logic                  wb_MemtoReg,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  illegal_instr
);

    localparam bit FWD_ON = (FWD_EN != 0);

    // A producer "hits" a source register when it writes a non-x0 rd equal to it.
    function automatic logic hits(input logic wr, input logic [REG_ADDR_W-1:0] rd,
                                  input logic [REG_ADDR_W-1:0] rs);
        return wr && (rd != '0) && (rd == rs);
    endfunction

    // EX/MEM result is newer than MEM/WB, so it takes priority.
    function automatic logic [1:0] fwd_sel(input logic wr1, input logic [REG_ADDR_W-1:0] rd1,
                                           input logic wr2, input logic [REG_ADDR_W-1:0] rd2,
                                           input logic [REG_ADDR_W-1:0] rs);
        if (hits(wr1, rd1, rs))      return FWD_EXMEM;
        else if (hits(wr2, rd2, rs)) return FWD_MEMWB;
        else                         return FWD_RF;
    endfunction

    ctrl_bundle_t id_ctrl;
    logic         id_illegal;

    ctrl_decoder #(.SUPPORT_JAL(SUPPORT_JAL)) u_dec (
        .opcode  (id_opcode),
        .ctrl    (id_ctrl),
        .illegal (id_illegal)
    );

    ctrl_bundle_t          ctrl_p0;
    logic [2:0]            funct3_p0;
    logic [REG_ADDR_W-1:0] rd_p0, rs1_p0, rs2_p0;
    logic                  mem_read_p1, mem_write_p1, reg_write_p1, memto_reg_p1;
    logic [REG_ADDR_W-1:0] rd_p1;
    logic                  reg_write_p2, memto_reg_p2;
    logic [REG_ADDR_W-1:0] rd_p2;

    logic load_use, raw_stall, stall, bubble_id;

    // Without forwarding, any pending write in EX or MEM to a source must wait.
    assign load_use  = hits(ctrl_p0.mem_read, rd_p0, id_rs1) ||
                       hits(ctrl_p0.mem_read, rd_p0, id_rs2);
    assign raw_stall = !FWD_ON &&
                       (hits(ctrl_p0.reg_write, rd_p0, id_rs1) ||
                        hits(ctrl_p0.reg_write, rd_p0, id_rs2) ||
                        hits(reg_write_p1, rd_p1, id_rs1) ||
                        hits(reg_write_p1, rd_p1, id_rs2));
    assign stall     = (load_use || raw_stall) && !branch_taken;
    assign bubble_id = stall || branch_taken;

    assign pc_write   = !reset || !stall;
    assign ifid_write = !reset || !stall;
    assign ifid_flush = reset && branch_taken;

    // ---- ID -> ID/EX stage boundary ----
    always_ff @(posedge clk) begin
        if (!reset || bubble_id) begin
            ctrl_p0   <= CTRL_NOP;
            funct3_p0 <= '0;
            rd_p0     <= '0;
            rs1_p0    <= '0;
            rs2_p0    <= '0;
        end else begin
            ctrl_p0   <= id_ctrl;
            funct3_p0 <= id_funct3;
            rd_p0     <= id_rd;
            rs1_p0    <= id_rs1;
            rs2_p0    <= id_rs2;
        end
    end

    // ---- EX -> EX/MEM stage boundary ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_read_p1  <= 1'b0;
            mem_write_p1 <= 1'b0;
            reg_write_p1 <= 1'b0;
            memto_reg_p1 <= 1'b0;
            rd_p1        <= '0;
        end else begin
            mem_read_p1  <= ctrl_p0.mem_read;
            mem_write_p1 <= ctrl_p0.mem_write;
            reg_write_p1 <= ctrl_p0.reg_write;
            memto_reg_p1 <= ctrl_p0.memto_reg;
            rd_p1        <= rd_p0;
        end
    end

    // ---- MEM -> MEM/WB stage boundary ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            reg_write_p2 <= 1'b0;
            memto_reg_p2 <= 1'b0;
            rd_p2        <= '0;
        end else begin
            reg_write_p2 <= reg_write_p1;
            memto_reg_p2 <= memto_reg_p1;
            rd_p2        <= rd_p1;
        end
    end

    // Sticky illegal-opcode flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset)          illegal_instr <= 1'b0;
        else if (id_illegal) illegal_instr <= 1'b1;
    end

    // Operand forwarding selects for the instruction currently in EX.
    always_comb begin
        forward_a = FWD_RF;
        forward_b = FWD_RF;
        if (FWD_ON && reset) begin
            forward_a = fwd_sel(reg_write_p1, rd_p1, reg_write_p2, rd_p2, rs1_p0);
            forward_b = fwd_sel(reg_write_p1, rd_p1, reg_write_p2, rd_p2, rs2_p0);
        end
    end

    assign ex_ALUSrc    = ctrl_p0.alu_src;
    assign ex_ALUOp     = ctrl_p0.alu_op;
    assign ex_Branch    = ctrl_p0.branch;
    assign ex_funct3    = funct3_p0;
    assign mem_MemRead  = mem_read_p1;
    assign mem_MemWrite = mem_write_p1;
    assign wb_RegWrite  = reg_write_p2;
    assign wb_MemtoReg  = memto_reg_p2;
    assign wb_rd        = rd_p2;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: a default instance plus a
// FWD_EN=0 / SUPPORT_JAL=1 instance sharing the same ID-stage stimulus.
module tb_pipelined_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] id_opcode;
    logic [2:0] id_funct3;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       branch_taken;

    logic       ex_ALUSrc, ex_Branch, mem_MemRead, mem_MemWrite, wb_RegWrite, wb_MemtoReg;
    logic [1:0] ex_ALUOp, forward_a, forward_b;
    logic [2:0] ex_funct3;
    logic [4:0] wb_rd;
    logic       pc_write, ifid_write, ifid_flush, illegal_instr;

    logic       n_ex_ALUSrc, n_ex_Branch, n_mem_MemRead, n_mem_MemWrite, n_wb_RegWrite, n_wb_MemtoReg;
    logic [1:0] n_ex_ALUOp, n_forward_a, n_forward_b;
    logic [2:0] n_ex_funct3;
    logic [4:0] n_wb_rd;
    logic       n_pc_write, n_ifid_write, n_ifid_flush, n_illegal;

    int tests = 0;
    int fails = 0;

    localparam logic [6:0] R = 7'b0110011, LD = 7'b0000011, ADDI = 7'b0010011;
    localparam logic [6:0] SD = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111;

    always #5 clk = ~clk;

    pipelined_control_unit u_dut (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_funct3(id_funct3),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .branch_taken(branch_taken),
        .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp), .ex_Branch(ex_Branch), .ex_funct3(ex_funct3),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .wb_RegWrite(wb_RegWrite),
        .wb_MemtoReg(wb_MemtoReg), .wb_rd(wb_rd), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .forward_a(forward_a), .forward_b(forward_b),
        .illegal_instr(illegal_instr)
    );

    pipelined_control_unit #(.REG_ADDR_W(5), .SUPPORT_JAL(1), .FWD_EN(0)) u_nofwd (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_funct3(id_funct3),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .branch_taken(branch_taken),
        .ex_ALUSrc(n_ex_ALUSrc), .ex_ALUOp(n_ex_ALUOp), .ex_Branch(n_ex_Branch), .ex_funct3(n_ex_funct3),
        .mem_MemRead(n_mem_MemRead), .mem_MemWrite(n_mem_MemWrite), .wb_RegWrite(n_wb_RegWrite),
        .wb_MemtoReg(n_wb_MemtoReg), .wb_rd(n_wb_rd), .pc_write(n_pc_write), .ifid_write(n_ifid_write),
        .ifid_flush(n_ifid_flush), .forward_a(n_forward_a), .forward_b(n_forward_b),
        .illegal_instr(n_illegal)
    );

    task automatic set_id(input logic [6:0] op, input logic [2:0] f3,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        id_opcode = op; id_funct3 = f3; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        set_id(7'b0, 3'b0, 5'd0, 5'd0, 5'd0);
        branch_taken = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; branch_taken = 1'b0;
        set_id(R, 3'b000, 5'd0, 5'd0, 5'd1);
        repeat (2) tick();
        tests++; if (ex_ALUOp !== 2'b00) begin fails++; $display("FAIL rst_aluop: got %b want 00", ex_ALUOp); end
        tests++; if (wb_RegWrite !== 1'b0) begin fails++; $display("FAIL rst_wb_regwrite: got %b want 0", wb_RegWrite); end
        tests++; if (mem_MemRead !== 1'b0 || mem_MemWrite !== 1'b0) begin fails++; $display("FAIL rst_mem: got %b%b want 00", mem_MemRead, mem_MemWrite); end
        tests++; if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin fails++; $display("FAIL rst_pcw: got %b%b want 11", pc_write, ifid_write); end
        tests++; if (ifid_flush !== 1'b0 || illegal_instr !== 1'b0) begin fails++; $display("FAIL rst_flush_ill: got %b%b want 00", ifid_flush, illegal_instr); end
        tests++; if (forward_a !== 2'b00 || forward_b !== 2'b00) begin fails++; $display("FAIL rst_fwd: got %b %b want 00 00", forward_a, forward_b); end
        tests++; if (n_pc_write !== 1'b1 || n_ex_ALUOp !== 2'b00) begin fails++; $display("FAIL rst_nofwd: got pcw=%b aluop=%b want 1 00", n_pc_write, n_ex_ALUOp); end
        reset = 1'b1;
        tick();
        tests++; if (ex_ALUOp !== 2'b10) begin fails++; $display("FAIL rel_ex_aluop: got %b want 10", ex_ALUOp); end
        tests++; if (wb_RegWrite !== 1'b0) begin fails++; $display("FAIL rel_wb_early: got %b want 0", wb_RegWrite); end
        repeat (2) tick();
        tests++; if (wb_RegWrite !== 1'b1 || wb_rd !== 5'd1) begin fails++; $display("FAIL rel_wb: got regwrite=%b rd=%0d want 1 1", wb_RegWrite, wb_rd); end
    endtask

    task automatic test_load_use();
        drain();
        set_id(LD, 3'b011, 5'd2, 5'd0, 5'd5);
        tick();
        set_id(R, 3'b000, 5'd5, 5'd7, 5'd6);
        #1;
        tests++; if (pc_write !== 1'b0 || ifid_write !== 1'b0) begin fails++; $display("FAIL lu_stall: got %b%b want 00", pc_write, ifid_write); end
        tests++; if (ex_ALUSrc !== 1'b1) begin fails++; $display("FAIL lu_ld_ex: got %b want 1", ex_ALUSrc); end
        tick();
        tests++; if (ex_ALUOp !== 2'b00 || ex_ALUSrc !== 1'b0 || ex_Branch !== 1'b0) begin fails++; $display("FAIL lu_bubble: got aluop=%b src=%b br=%b want 00 0 0", ex_ALUOp, ex_ALUSrc, ex_Branch); end
        tests++; if (mem_MemRead !== 1'b1) begin fails++; $display("FAIL lu_memread: got %b want 1", mem_MemRead); end
        tests++; if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin fails++; $display("FAIL lu_one_cycle: got %b%b want 11", pc_write, ifid_write); end
        tick();
        set_id(7'b0, 3'b0, 5'd0, 5'd0, 5'd0);
        #1;
        tests++; if (ex_ALUOp !== 2'b10) begin fails++; $display("FAIL lu_add_ex: got %b want 10", ex_ALUOp); end
        tests++; if (forward_a !== 2'b01 || forward_b !== 2'b00) begin fails++; $display("FAIL lu_fwd: got %b %b want 01 00", forward_a, forward_b); end
        tests++; if (wb_MemtoReg !== 1'b1 || wb_rd !== 5'd5) begin fails++; $display("FAIL lu_wb: got m2r=%b rd=%0d want 1 5", wb_MemtoReg, wb_rd); end
    endtask

    task automatic test_forward();
        drain();
        set_id(R, 3'b000, 5'd1, 5'd2, 5'd3);
        tick();
        set_id(R, 3'b000, 5'd3, 5'd3, 5'd4);
        #1;
        tests++; if (pc_write !== 1'b1) begin fails++; $display("FAIL fw_nostall: got %b want 1", pc_write); end
        tick();
        set_id(7'b0, 3'b0, 5'd0, 5'd0, 5'd0);
        #1;
        tests++; if (forward_a !== 2'b10 || forward_b !== 2'b10) begin fails++; $display("FAIL fw_exmem: got %b %b want 10 10", forward_a, forward_b); end
        drain();
        set_id(R, 3'b000, 5'd1, 5'd2, 5'd0);
        tick();
        set_id(R, 3'b000, 5'd0, 5'd0, 5'd4);
        tick();
        tests++; if (forward_a !== 2'b00 || forward_b !== 2'b00) begin fails++; $display("FAIL fw_x0: got %b %b want 00 00", forward_a, forward_b); end
        drain();
        set_id(R, 3'b000, 5'd1, 5'd2, 5'd3);
        tick();
        tick();
        set_id(R, 3'b000, 5'd3, 5'd9, 5'd4);
        tick();
        tests++; if (forward_a !== 2'b10 || forward_b !== 2'b00) begin fails++; $display("FAIL fw_priority: got %b %b want 10 00", forward_a, forward_b); end
    endtask

    task automatic test_flush();
        drain();
        set_id(LD, 3'b011, 5'd2, 5'd0, 5'd5);
        tick();
        set_id(R, 3'b000, 5'd5, 5'd7, 5'd6);
        branch_taken = 1'b1;
        #1;
        tests++; if (ifid_flush !== 1'b1) begin fails++; $display("FAIL fl_flush: got %b want 1", ifid_flush); end
        tests++; if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin fails++; $display("FAIL fl_over_stall: got %b%b want 11", pc_write, ifid_write); end
        tick();
        branch_taken = 1'b0;
        set_id(7'b0, 3'b0, 5'd0, 5'd0, 5'd0);
        #1;
        tests++; if (ex_ALUOp !== 2'b00 || ex_ALUSrc !== 1'b0) begin fails++; $display("FAIL fl_bubble: got aluop=%b src=%b want 00 0", ex_ALUOp, ex_ALUSrc); end
        tests++; if (mem_MemRead !== 1'b1 || ifid_flush !== 1'b0) begin fails++; $display("FAIL fl_exmem: got memread=%b flush=%b want 1 0", mem_MemRead, ifid_flush); end
    endtask

    task automatic test_decode();
        drain();
        set_id(BR, 3'b101, 5'd1, 5'd2, 5'd0);
        tick();
        tests++; if (ex_Branch !== 1'b1 || ex_ALUOp !== 2'b01 || ex_funct3 !== 3'b101 || ex_ALUSrc !== 1'b0) begin fails++; $display("FAIL dec_br: got br=%b op=%b f3=%b src=%b want 1 01 101 0", ex_Branch, ex_ALUOp, ex_funct3, ex_ALUSrc); end
        set_id(SD, 3'b011, 5'd1, 5'd2, 5'd0);
        tick();
        tests++; if (ex_ALUSrc !== 1'b1 || ex_ALUOp !== 2'b00 || ex_Branch !== 1'b0) begin fails++; $display("FAIL dec_sd: got src=%b op=%b br=%b want 1 00 0", ex_ALUSrc, ex_ALUOp, ex_Branch); end
        set_id(ADDI, 3'b000, 5'd1, 5'd0, 5'd9);
        tick();
        tests++; if (mem_MemWrite !== 1'b1 || mem_MemRead !== 1'b0 || ex_ALUSrc !== 1'b1) begin fails++; $display("FAIL dec_sd_mem: got mw=%b mr=%b src=%b want 1 0 1", mem_MemWrite, mem_MemRead, ex_ALUSrc); end
        set_id(7'b0, 3'b0, 5'd0, 5'd0, 5'd0);
        tick();
        tests++; if (mem_MemWrite !== 1'b0 || wb_RegWrite !== 1'b0) begin fails++; $display("FAIL dec_addi_mem: got mw=%b wbrw=%b want 0 0", mem_MemWrite, wb_RegWrite); end
        tick();
        tests++; if (wb_RegWrite !== 1'b1 || wb_rd !== 5'd9 || wb_MemtoReg !== 1'b0) begin fails++; $display("FAIL dec_addi_wb: got rw=%b rd=%0d m2r=%b want 1 9 0", wb_RegWrite, wb_rd, wb_MemtoReg); end
    endtask

    task automatic test_illegal();
        drain();
        tests++; if (illegal_instr !== 1'b0) begin fails++; $display("FAIL ill_bubble: got %b want 0", illegal_instr); end
        set_id(7'b1111111, 3'b0, 5'd0, 5'd0, 5'd0);
        #1;
        tests++; if (illegal_instr !== 1'b0) begin fails++; $display("FAIL ill_early: got %b want 0", illegal_instr); end
        tick();
        tests++; if (illegal_instr !== 1'b1 || ex_ALUOp !== 2'b00 || ex_ALUSrc !== 1'b0) begin fails++; $display("FAIL ill_set: got ill=%b op=%b src=%b want 1 00 0", illegal_instr, ex_ALUOp, ex_ALUSrc); end
        set_id(R, 3'b000, 5'd0, 5'd0, 5'd1);
        repeat (2) tick();
        tests++; if (illegal_instr !== 1'b1) begin fails++; $display("FAIL ill_sticky: got %b want 1", illegal_instr); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        set_id(7'b0, 3'b0, 5'd0, 5'd0, 5'd0);
        #1;
        tests++; if (illegal_instr !== 1'b0 || ex_ALUOp !== 2'b00) begin fails++; $display("FAIL ill_reset: got ill=%b op=%b want 0 00", illegal_instr, ex_ALUOp); end
        set_id(JAL, 3'b000, 5'd0, 5'd0, 5'd1);
        tick();
        tests++; if (illegal_instr !== 1'b1 || ex_ALUOp !== 2'b00) begin fails++; $display("FAIL jal_illegal: got ill=%b op=%b want 1 00", illegal_instr, ex_ALUOp); end
        tests++; if (n_illegal !== 1'b0 || n_ex_ALUOp !== 2'b11) begin fails++; $display("FAIL jal_decode: got ill=%b op=%b want 0 11", n_illegal, n_ex_ALUOp); end
        set_id(7'b0, 3'b0, 5'd0, 5'd0, 5'd0);
        repeat (2) tick();
        tests++; if (n_wb_RegWrite !== 1'b1 || n_wb_rd !== 5'd1 || wb_RegWrite !== 1'b0) begin fails++; $display("FAIL jal_wb: got n_rw=%b n_rd=%0d rw=%b want 1 1 0", n_wb_RegWrite, n_wb_rd, wb_RegWrite); end
    endtask

    task automatic test_no_forward();
        drain();
        set_id(R, 3'b000, 5'd1, 5'd2, 5'd3);
        tick();
        set_id(R, 3'b000, 5'd3, 5'd1, 5'd4);
        #1;
        tests++; if (n_pc_write !== 1'b0 || n_ifid_write !== 1'b0) begin fails++; $display("FAIL nf_stall1: got %b%b want 00", n_pc_write, n_ifid_write); end
        tests++; if (pc_write !== 1'b1) begin fails++; $display("FAIL nf_fwd_dut_nostall: got %b want 1", pc_write); end
        tick();
        tests++; if (n_pc_write !== 1'b0 || n_ex_ALUOp !== 2'b00) begin fails++; $display("FAIL nf_stall2: got pcw=%b op=%b want 0 00", n_pc_write, n_ex_ALUOp); end
        tick();
        tests++; if (n_pc_write !== 1'b1 || n_forward_a !== 2'b00) begin fails++; $display("FAIL nf_release: got pcw=%b fa=%b want 1 00", n_pc_write, n_forward_a); end
        tick();
        tests++; if (n_ex_ALUOp !== 2'b10 || n_forward_a !== 2'b00 || n_forward_b !== 2'b00) begin fails++; $display("FAIL nf_issue: got op=%b fa=%b fb=%b want 10 00 00", n_ex_ALUOp, n_forward_a, n_forward_b); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forward();
        test_flush();
        test_decode();
        test_illegal();
        test_no_forward();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
